// File: rtl/apb_pkg.sv
// Shared types for the APB command master: FSM state encoding and the queued command record.
// Command fields are sized for the widest legal configuration; narrower instances use the low bits.
package apb_pkg;

  localparam int CMD_AW_MAX = 32;
  localparam int CMD_DW_MAX = 32;
  localparam int CMD_SW_MAX = CMD_DW_MAX / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [CMD_AW_MAX-1:0] addr;
    logic [CMD_DW_MAX-1:0] wdata;
    logic                  write;
    logic [CMD_SW_MAX-1:0] strb;
    logic [2:0]            prot;
  } apb_cmd_t;

  // Reads never present byte strobes on the bus.
  function automatic apb_cmd_t bus_view(apb_cmd_t c);
    apb_cmd_t r;
    r = c;
    if (!c.write) r.strb = '0;
    return r;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB signal bundle for apb_cmd_master.
// master: the DUT side; slave: the command producer / APB completer side.
interface apb_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  cmd_write;
  logic [STRB_WIDTH-1:0] cmd_strb;
  logic [2:0]            cmd_prot;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_write, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_write, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command queue; pointers carry one extra wrap bit to tell full from empty.
// Head is presented combinationally on dout whenever the queue is non-empty.
module apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign dout  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (pop && !empty) rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end
endmodule

// File: rtl/apb_cmd_master.sv
// Queued APB requester: buffers commands, issues them in order as SETUP/ACCESS transfers
// and returns a one-cycle response per transfer, aborting on a wait-state timeout.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              pclk,
  input logic              presetn,
  apb_cmd_master_if.master bus
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int SW = DATA_WIDTH / 8;

  apb_state_e            state_q, state_d;
  apb_cmd_t              xfer_q, xfer_d;
  apb_cmd_t              push_cmd, head_cmd;
  logic [CW-1:0]         wait_q, wait_d;
  logic                  rdy_en_q;
  logic                  fifo_full, fifo_empty, pop;
  logic                  free, timed_out;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    push_cmd       = '0;
    push_cmd.addr  = CMD_AW_MAX'(bus.cmd_addr);
    push_cmd.wdata = CMD_DW_MAX'(bus.cmd_wdata);
    push_cmd.write = bus.cmd_write;
    push_cmd.strb  = CMD_SW_MAX'(bus.cmd_strb);
    push_cmd.prot  = bus.cmd_prot;
  end

  // Held off through reset and for the first cycle after it.
  assign bus.cmd_ready = rdy_en_q && !fifo_full;

  apb_cmd_fifo #(.WIDTH($bits(apb_cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (pclk),
    .rst_n (presetn),
    .push  (bus.cmd_valid && bus.cmd_ready),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign timed_out = (TIMEOUT_CYCLES != 0) && (state_q == ST_ACCESS) && !bus.pready &&
                     (wait_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d       = state_q;
    xfer_d        = xfer_q;
    wait_d        = wait_q;
    pop           = 1'b0;
    free          = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      ST_IDLE:  free = 1'b1;
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.pready) begin
          free          = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = xfer_q.write ? '0 : bus.prdata;
        end else if (timed_out) begin
          free          = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A finishing transfer chains straight into the next queued command.
    if (free) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        xfer_d  = bus_view(head_cmd);
        wait_d  = '0;
        state_d = ST_SETUP;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= ST_IDLE;
      xfer_q        <= '0;
      wait_q        <= '0;
      rdy_en_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      xfer_q        <= xfer_d;
      wait_q        <= wait_d;
      rdy_en_q      <= 1'b1;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign bus.psel        = (state_q != ST_IDLE);
  assign bus.penable     = (state_q == ST_ACCESS);
  assign bus.pwrite      = xfer_q.write;
  assign bus.paddr       = xfer_q.addr[ADDR_WIDTH-1:0];
  assign bus.pwdata      = xfer_q.wdata[DATA_WIDTH-1:0];
  assign bus.pstrb       = xfer_q.strb[SW-1:0];
  assign bus.pprot       = xfer_q.prot;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model (pending-command queue, bus phase rules, response rules).
module tb_apb_cmd_master;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  p;
  } cmd_s;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- completer (slave) behaviour ----------------
  int          force_wait = -1;
  int          force_err  = -1;
  logic        force_rd_en = 1'b0;
  logic [31:0] force_rd   = '0;
  logic        hang       = 1'b0;
  int          plan_w = 0;
  int          acc_i  = 0;

  always @(posedge pclk) begin
    #1;
    bus.pready = 1'b0;
    if (bus.psel && !bus.penable) begin
      plan_w = (force_wait >= 0) ? force_wait :
               (($urandom % 16 == 0) ? 20 : int'($urandom_range(0, 4)));
      acc_i = 0;
    end else if (bus.psel && bus.penable) begin
      bus.pready = !hang && (acc_i >= plan_w);
      acc_i++;
    end
    bus.prdata  = force_rd_en ? force_rd : $urandom;
    bus.pslverr = (force_err >= 0) ? force_err[0] : ($urandom % 8 == 0);
  end

  // ---------------- behavioural model + compare ----------------
  cmd_s        pend[$];
  cmd_s        cur;
  int          exp_phase = 0;
  int          waits = 0, len = 0, last_len = 0;
  int          rsp_cnt = 0, acc_cnt = 0, dut_pulses = 0;
  logic        exp_rv = 1'b0, exp_err = 1'b0, exp_to = 1'b0;
  logic [31:0] exp_rd = '0;
  logic        last_err = 1'b0, last_to = 1'b0;
  logic [31:0] last_rd = '0;
  logic [3:0]  last_pstrb = '0;
  logic        ready_en_m = 1'b0;

  always @(posedge pclk or negedge presetn) ready_en_m <= presetn;

  always @(negedge pclk) begin : compare
    int ph;
    if (bus.rsp_valid) dut_pulses++;
    if (!presetn) begin
      chk("reset_outputs",
          {52'd0, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err,
           bus.rsp_timeout, bus.cmd_ready, bus.pstrb, bus.pprot},
          64'd0);
      chk("reset_addr_data", {bus.paddr, bus.pwdata}, 64'd0);
      pend.delete();
      exp_phase = 0;
      exp_rv    = 1'b0;
    end else begin
      chk("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, exp_rv});
      if (exp_rv) begin
        rsp_cnt++;
        chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, exp_err});
        chk("rsp_timeout", {63'd0, bus.rsp_timeout}, {63'd0, exp_to});
        if (!exp_to) chk("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, exp_rd});
        last_err = bus.rsp_err;
        last_to  = bus.rsp_timeout;
        last_rd  = bus.rsp_rdata;
      end
      exp_rv = 1'b0;

      ph = !bus.psel ? 0 : (!bus.penable ? 1 : 2);
      chk("bus_phase", 64'(ph), 64'(exp_phase));
      if (ph == 1) begin
        if (pend.size() == 0) chk("setup_without_cmd", 64'd1, 64'd0);
        else cur = pend.pop_front();
        waits = 0;
        len = 1;
        last_pstrb = bus.pstrb;
      end else if (ph == 2) begin
        len++;
      end
      if (ph != 0) begin
        chk("paddr_pwdata", {bus.paddr, bus.pwdata}, {cur.a, cur.d});
        chk("pwrite_pstrb_pprot", {56'd0, bus.pwrite, bus.pstrb, bus.pprot},
            {56'd0, cur.w, (cur.w ? cur.s : 4'h0), cur.p});
      end
      chk("cmd_ready", {63'd0, bus.cmd_ready}, {63'd0, ready_en_m && (pend.size() < DEPTH)});

      if (ph == 0) begin
        exp_phase = (pend.size() > 0) ? 1 : 0;
      end else if (ph == 1) begin
        exp_phase = 2;
      end else if (bus.pready || waits == TMO) begin
        exp_rv   = 1'b1;
        exp_err  = bus.pready ? bus.pslverr : 1'b1;
        exp_to   = !bus.pready;
        exp_rd   = (bus.pready && !cur.w) ? bus.prdata : 32'd0;
        last_len = len;
        exp_phase = (pend.size() > 0) ? 1 : 0;
      end else begin
        waits++;
        exp_phase = 2;
      end

      if (bus.cmd_valid && bus.cmd_ready) begin
        pend.push_back('{bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_strb, bus.cmd_prot});
        acc_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  logic saw_busy = 1'b0;

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    bus.cmd_prot  = p;
    do begin
      @(negedge pclk);
      if (!bus.cmd_ready) saw_busy = 1'b1;
      n++;
    end while (!bus.cmd_ready && n < 200);
    if (!bus.cmd_ready) chk("send_accept_bound", 64'd0, 64'd1);
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 2000) begin
      @(posedge pclk);
      #1;
      n++;
    end
    if (rsp_cnt < target) chk("wait_rsp_bound", 64'(rsp_cnt), 64'(target));
  endtask

  task automatic clear_forces();
    force_wait  = -1;
    force_err   = -1;
    force_rd_en = 1'b0;
    hang        = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int base, n, pulses;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;

    // Reset state and ready release timing
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_psel_ready", {62'd0, bus.psel, bus.cmd_ready}, 64'd0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("ready_before_first_edge", {63'd0, bus.cmd_ready}, 64'd0);
    @(posedge pclk);
    #1;
    chk("ready_after_first_edge", {63'd0, bus.cmd_ready}, 64'd1);

    // Zero-wait write
    force_wait = 0; force_err = 0;
    base = rsp_cnt;
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2);
    wait_rsp(base + 1);
    chk("wr_len", 64'(last_len), 64'd2);
    chk("wr_err_to", {62'd0, last_err, last_to}, 64'd0);

    // Read with three wait states; strobes must read zero
    force_wait = 3; force_rd_en = 1'b1; force_rd = 32'h1234_5678;
    base = rsp_cnt;
    send(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 3'd0);
    wait_rsp(base + 1);
    chk("rd_len", 64'(last_len), 64'd5);
    chk("rd_rdata", {32'd0, last_rd}, 64'h1234_5678);
    chk("rd_pstrb", {60'd0, last_pstrb}, 64'd0);
    clear_forces();

    // Slave error on a write
    force_wait = 1; force_err = 1;
    base = rsp_cnt;
    send(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 4'h3, 3'd1);
    wait_rsp(base + 1);
    chk("slverr_err_to", {62'd0, last_err, last_to}, 64'd2);
    clear_forces();

    // Timeout, then the queued command still issues
    hang = 1'b1; force_err = 0;
    base = rsp_cnt;
    send(1'b1, 32'h0000_0100, 32'h1111_2222, 4'hF, 3'd0);
    send(1'b0, 32'h0000_0104, 32'h0, 4'h0, 3'd0);
    wait_rsp(base + 1);
    chk("tmo_err_to", {62'd0, last_err, last_to}, 64'd3);
    chk("tmo_len", 64'(last_len), 64'(TMO + 2));
    hang = 1'b0; force_wait = 0;
    wait_rsp(base + 2);
    chk("after_tmo_to", {63'd0, last_to}, 64'd0);
    clear_forces();

    // Back-to-back burst fills the queue; model checks order and no idle gaps
    force_wait = 2;
    saw_busy = 1'b0;
    base = rsp_cnt;
    for (int i = 0; i < 6; i++)
      send(i[0], 32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1), 3'(i));
    chk("burst_ready_dropped", {63'd0, saw_busy}, 64'd1);
    wait_rsp(base + 6);
    chk("burst_last_len", 64'(last_len), 64'd4);
    clear_forces();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.cmd_valid = ($urandom % 2) == 0;
      bus.cmd_write = $urandom;
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      bus.cmd_strb  = $urandom;
      bus.cmd_prot  = $urandom;
      @(posedge pclk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    wait_rsp(acc_cnt);

    // Reset during ACCESS with two commands queued
    hang = 1'b1;
    send(1'b1, 32'h300, 32'h3, 4'hF, 3'd0);
    send(1'b1, 32'h304, 32'h4, 4'hF, 3'd0);
    send(1'b0, 32'h308, 32'h5, 4'hF, 3'd0);
    n = 0;
    while (!(bus.psel && bus.penable) && n < 50) begin
      @(posedge pclk);
      #1;
      n++;
    end
    chk("reached_access", {63'd0, bus.psel && bus.penable}, 64'd1);
    pulses = dut_pulses;
    presetn = 1'b0;
    #1;
    chk("async_reset_bus", {61'd0, bus.psel, bus.penable, bus.rsp_valid}, 64'd0);
    chk("async_reset_addr", {bus.paddr, bus.pwdata}, 64'd0);
    chk("async_reset_ready", {63'd0, bus.cmd_ready}, 64'd0);
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b1;
    hang = 1'b0;
    repeat (12) @(posedge pclk);
    #1;
    chk("no_rsp_after_reset", 64'(dut_pulses), 64'(pulses));
    chk("idle_after_reset", {63'd0, bus.psel}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set PWDATA/PRDATA width; legal values 8, 16, 32.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set PADDR width.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set command queue depth; power of two, >=2.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, SHALL set max wait cycles in ACCESS; 0 disables timeout.
REQ-005 Ports SHALL be: pclk in 1, APB clock; presetn in 1, reset.
REQ-006 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-007 Ports SHALL be: cmd_valid in 1; cmd_ready out 1; cmd_addr in ADDR_WIDTH; cmd_wdata in DATA_WIDTH; cmd_write in 1; cmd_strb in DATA_WIDTH/8; cmd_prot in 3.
REQ-008 Ports SHALL be: rsp_valid out 1 (one-cycle pulse); rsp_rdata out DATA_WIDTH; rsp_err out 1; rsp_timeout out 1.
REQ-009 Ports SHALL be: psel, penable, pwrite out 1; paddr out ADDR_WIDTH; pwdata out DATA_WIDTH; pstrb out DATA_WIDTH/8; pprot out 3; pready, pslverr in 1; prdata in DATA_WIDTH.

Function
REQ-010 Command accepted on a pclk edge with cmd_valid && cmd_ready; cmd_ready = FIFO not full.
REQ-011 Accepted commands SHALL be issued on APB in strict acceptance order.
REQ-012 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-013 IDLE: FIFO non-empty -> pop head, load transfer registers, go SETUP next cycle; psel=0, penable=0.
REQ-014 SETUP: psel=1, penable=0, always -> ACCESS.
REQ-015 ACCESS: psel=1, penable=1; pready=1 -> complete; pready=0 -> stay, increment wait counter.
REQ-016 On completion with FIFO non-empty, SHALL go directly to SETUP with next command (no IDLE cycle); else IDLE.
REQ-017 Minimum transfer is 2 cycles; back-to-back zero-wait throughput SHALL be one transfer per 2 cycles.
REQ-018 paddr, pwrite, pwdata, pstrb, pprot SHALL be stable from SETUP through the final ACCESS cycle.
REQ-019 pstrb SHALL be driven all-zero for reads regardless of cmd_strb.
REQ-020 On completion, rsp_valid=1 the following cycle; rsp_err=pslverr sampled at completion; rsp_timeout=0.
REQ-021 rsp_rdata SHALL hold prdata sampled at completion for reads; all-zero for writes.
REQ-022 Wait counter SHALL reset to 0 on SETUP entry; when it reaches TIMEOUT_CYCLES (non-zero) with pready=0, transfer aborts: psel/penable drop next cycle, rsp_valid=1, rsp_err=1, rsp_timeout=1.
REQ-023 After a timeout, FSM SHALL proceed as in REQ-016.
REQ-024 Push and pop in the same cycle on a full FIFO SHALL NOT be allowed (cmd_ready=0 when full); on an empty FIFO, a pushed command SHALL NOT be popped in the same cycle.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty via extra pointer bit.
REQ-026 rsp outputs SHALL NOT be back-pressured; consumer must accept every pulse.

Reset
REQ-027 On presetn low, immediately: state IDLE, FIFO emptied, psel=0, penable=0, pwrite=0, paddr/pwdata/pstrb/pprot=0, rsp_valid/rsp_err/rsp_timeout=0, rsp_rdata=0, cmd_ready=0.
REQ-028 cmd_ready SHALL assert the first cycle after presetn deasserts.
REQ-029 Reset mid-transfer SHALL abort silently: no rsp_valid pulse for the dropped or queued commands.

Structure
REQ-030 Shared package apb_pkg SHALL hold the state enum and the command struct (addr, wdata, write, strb, prot).
REQ-031 Command queue SHALL be a sub-module apb_cmd_fifo (synchronous, parametrised width/depth).

Verification
REQ-032 Write 0x0000_0010 <- 0xDEADBEEF, strb 0xF, pready=1: SETUP then ACCESS, 2 cycles; rsp_valid, rsp_err=0.
REQ-033 Read 0x20, pready low 3 cycles, prdata=0x12345678: 5-cycle transfer; rsp_rdata=0x12345678; pstrb=0.
REQ-034 Push 4 commands back-to-back (DEPTH=4): cmd_ready drops when full; 4 transfers with no IDLE gap, in order.
REQ-035 TIMEOUT_CYCLES=16, pready held 0: abort after 16 wait cycles; rsp_err=1, rsp_timeout=1; next command issues.
REQ-036 pslverr=1 on completion of a write: rsp_err=1, rsp_timeout=0.
REQ-037 presetn low during ACCESS with 2 queued: outputs zero immediately; no rsp pulses; FIFO empty after release.
